// File: rtl/mig_ui_responder.sv
// mig_ui_responder: behavioural stand-in for a MIG user interface.
// After a fixed calibration delay it accepts 128-bit byte-masked writes and
// fixed-latency reads against an on-chip word store. It periodically drops
// ready for a refresh window and flags illegal commands in a sticky error bit.
module mig_ui_responder #(
    parameter int DEPTH_WORDS    = 256,
    parameter int RD_LATENCY     = 4,
    parameter int CALIB_CYCLES   = 16,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_LEN    = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [26:0]  app_addr,
    input  logic [2:0]   app_cmd,
    input  logic         app_en,
    input  logic [127:0] app_wdf_data,
    input  logic         app_wdf_end,
    input  logic         app_wdf_wren,
    input  logic [15:0]  app_wdf_mask,
    output logic         app_rdy,
    output logic         app_wdf_rdy,
    output logic [127:0] app_rd_data,
    output logic         app_rd_data_valid,
    output logic         app_rd_data_end,
    output logic         init_calib_complete,
    output logic         proto_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_PERIOD);

    localparam logic [CW-1:0] CALIB_LAST  = CW'(CALIB_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST    = RW'(REFRESH_PERIOD - 1);
    localparam logic [RW-1:0] STALL_FIRST = RW'(REFRESH_PERIOD - REFRESH_LEN);

    typedef enum logic {
        ST_CALIB,
        ST_RUN
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   calib_cnt_q;
    logic [RW-1:0]   refresh_cnt_q;
    logic            proto_err_q;
    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [127:0]    rd_word;
    logic [127:0]    data_pipe_q [RD_LATENCY-1];

    logic            run;
    logic            stall;
    logic            cmd_fire;
    logic            is_wr;
    logic            is_rd;
    logic            wr_commit;
    logic            rd_accept;
    logic            bad_cmd;
    logic [AW-1:0]   idx;

    // Address bits below the word boundary and above the index only alias.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^app_addr;

    // Ready depends only on state so a master may sample it before driving app_en.
    assign run     = (state_q == ST_RUN);
    assign stall   = (refresh_cnt_q >= STALL_FIRST);
    assign app_rdy = run && !stall;
    assign app_wdf_rdy         = app_rdy;
    assign init_calib_complete = run;

    assign idx       = app_addr[3 +: AW];
    assign cmd_fire  = app_en && app_rdy;
    assign is_wr     = (app_cmd == 3'b000);
    assign is_rd     = (app_cmd == 3'b001);
    assign wr_commit = cmd_fire && is_wr && app_wdf_wren && app_wdf_rdy && app_wdf_end;
    assign rd_accept = cmd_fire && is_rd;
    assign bad_cmd   = cmd_fire && (!(is_wr || is_rd) || (is_wr && !(app_wdf_wren && app_wdf_end)));

    // Calibration countdown, then free-running refresh counter while running.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= ST_CALIB;
            calib_cnt_q   <= '0;
            refresh_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_CALIB: begin
                    if (calib_cnt_q == CALIB_LAST) begin
                        state_q       <= ST_RUN;
                        refresh_cnt_q <= '0;
                    end else begin
                        calib_cnt_q <= calib_cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    refresh_cnt_q <= (refresh_cnt_q == REF_LAST) ? '0 : refresh_cnt_q + RW'(1);
                end
                default: state_q <= ST_CALIB;
            endcase
        end
    end

    // Sticky protocol error; the offending command is simply not executed.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            proto_err_q <= 1'b0;
        end else if (bad_cmd) begin
            proto_err_q <= 1'b1;
        end
    end
    assign proto_err = proto_err_q;

    // One byte-wide store per lane so the mask maps onto native byte enables.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_q;

            // Lane write with mask, plus registered read on read acceptance.
            always_ff @(posedge clk_in) begin
                if (wr_commit && !app_wdf_mask[gi]) begin
                    lane_mem[idx] <= app_wdf_data[gi*8 +: 8];
                end
                if (rd_accept) begin
                    rd_byte_q <= lane_mem[idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_q;
        end
    endgenerate

    // Valid tracker; cleared by reset so in-flight reads vanish.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q <= {rd_vld_q[RD_LATENCY-2:0], rd_accept};
        end
    end

    // Data delay line aligned with the valid tracker; the memory read is stage zero.
    generate
        for (genvar gi = 0; gi < RD_LATENCY - 1; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                // First delay stage takes the registered memory word.
                always_ff @(posedge clk_in) begin
                    data_pipe_q[gi] <= rd_word;
                end
            end else begin : g_next
                // Later stages just shift.
                always_ff @(posedge clk_in) begin
                    data_pipe_q[gi] <= data_pipe_q[gi-1];
                end
            end
        end
    endgenerate

    // Data is forced to zero whenever no response is being presented.
    assign app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
    assign app_rd_data_end   = rd_vld_q[RD_LATENCY-1];
    assign app_rd_data       = rd_vld_q[RD_LATENCY-1] ? data_pipe_q[RD_LATENCY-2] : '0;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench for mig_ui_responder: a small reference model tracks
// calibration, refresh, memory contents and expected read responses; every
// cycle the DUT outputs are compared, plus hand-computed spot checks.
module tb_mig_ui_responder;

    localparam int RD_LAT = 4;
    localparam int CALIB  = 16;
    localparam int PERIOD = 64;
    localparam int RLEN   = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic [127:0] app_wdf_data;
    logic         app_wdf_end;
    logic         app_wdf_wren;
    logic [15:0]  app_wdf_mask;
    logic         app_rdy;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;
    logic         proto_err;

    always #5 clk = ~clk;

    mig_ui_responder #(
        .DEPTH_WORDS(256), .RD_LATENCY(RD_LAT), .CALIB_CYCLES(CALIB),
        .REFRESH_PERIOD(PERIOD), .REFRESH_LEN(RLEN)
    ) dut (
        .clk_in(clk), .rst_in(rst_n),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .app_wdf_wren(app_wdf_wren), .app_wdf_mask(app_wdf_mask),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end),
        .init_calib_complete(init_calib_complete), .proto_err(proto_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    logic [127:0] mem_m [256];
    bit  m_run  = 1'b0;
    int  m_cal  = 0;
    int  m_ref  = 0;
    bit  m_perr = 1'b0;
    typedef struct {
        int           due;
        logic [127:0] data;
    } rsp_t;
    rsp_t rq[$];

    function automatic bit exp_rdy();
        return m_run && (m_ref < PERIOD - RLEN);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=ready within bound", tag);
    endtask

    // One clock: update the model at the edge, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_run = 1'b0; m_cal = 0; m_ref = 0; m_perr = 1'b0;
            rq.delete();
        end else begin
            if (exp_rdy() && app_en) begin
                int wi;
                wi = int'(app_addr[10:3]);
                if (app_cmd == 3'b001) begin
                    rq.push_back('{cyc + RD_LAT, mem_m[wi]});
                end else if (app_cmd == 3'b000 && app_wdf_wren && app_wdf_end) begin
                    for (int b = 0; b < 16; b++)
                        if (!app_wdf_mask[b]) mem_m[wi][b*8 +: 8] = app_wdf_data[b*8 +: 8];
                end else begin
                    m_perr = 1'b1;
                end
            end
            if (!m_run) begin
                m_cal++;
                if (m_cal == CALIB) begin m_run = 1'b1; m_ref = 0; end
            end else begin
                m_ref = (m_ref + 1) % PERIOD;
            end
        end
        cyc++;
        #1;
        check("app_rdy", {127'd0, app_rdy}, {127'd0, exp_rdy()});
        check("app_wdf_rdy", {127'd0, app_wdf_rdy}, {127'd0, exp_rdy()});
        check("calib", {127'd0, init_calib_complete}, {127'd0, m_run});
        check("proto_err", {127'd0, proto_err}, {127'd0, m_perr});
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("rd_valid", {127'd0, app_rd_data_valid}, 128'd1);
            check("rd_end", {127'd0, app_rd_data_end}, 128'd1);
            check("rd_data", app_rd_data, rq[0].data);
            void'(rq.pop_front());
        end else begin
            check("rd_valid_idle", {127'd0, app_rd_data_valid}, 128'd0);
            check("rd_end_idle", {127'd0, app_rd_data_end}, 128'd0);
            check("rd_data_idle", app_rd_data, 128'd0);
        end
        $display("cyc=%0d rst_n=%0b en=%0b cmd=%0d addr=%h rdy=%0b vld=%0b data=%h perr=%0b",
                 cyc, rst_n, app_en, app_cmd, app_addr, app_rdy, app_rd_data_valid, app_rd_data, proto_err);
    endtask

    // Hold a command until the model says it is accepted, then drop it.
    task automatic issue(input logic [2:0] cmd, input logic [26:0] addr, input logic wren,
                         input logic [127:0] data, input logic [15:0] mask);
        int guard;
        app_en = 1'b1; app_cmd = cmd; app_addr = addr;
        app_wdf_wren = wren; app_wdf_end = wren; app_wdf_data = data; app_wdf_mask = mask;
        guard = 0;
        while (!exp_rdy() && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) timeout_fail("issue_wait");
        tick();
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic wait_ref(input int target);
        int guard;
        guard = 0;
        while (m_ref != target && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) timeout_fail("wait_ref");
    endtask

    initial begin
        int stall_dut;
        int guard;
        rst_n = 1'b0; app_en = 1'b0; app_cmd = 3'd0; app_addr = '0;
        app_wdf_data = '0; app_wdf_end = 1'b0; app_wdf_wren = 1'b0; app_wdf_mask = '0;

        // Reset state
        repeat (3) tick();
        check("rst_rdy", {127'd0, app_rdy}, 128'd0);
        check("rst_calib", {127'd0, init_calib_complete}, 128'd0);
        check("rst_data", app_rd_data, 128'd0);

        // Calibration: rises exactly on the 16th edge after release
        rst_n = 1'b1;
        repeat (CALIB - 1) tick();
        check("calib_15th", {127'd0, init_calib_complete}, 128'd0);
        tick();
        check("calib_16th", {127'd0, init_calib_complete}, 128'd1);
        check("rdy_16th", {127'd0, app_rdy}, 128'd1);

        // Stray write data with no command: ignored, no error
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = {4{32'hDEADBEEF}};
        repeat (2) tick();
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        check("stray_wren_perr", {127'd0, proto_err}, 128'd0);

        // Write/readback at 0x40
        issue(3'b000, 27'h40, 1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h0000);
        issue(3'b001, 27'h40, 1'b0, '0, '0);
        repeat (RD_LAT - 1) tick();
        check("wr_rd_valid", {127'd0, app_rd_data_valid}, 128'd1);
        check("wr_rd_data", app_rd_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        repeat (3) tick();

        // Masked write through an aliasing address
        issue(3'b000, 27'h08, 1'b1, {128{1'b1}}, 16'h0000);
        issue(3'b000, 27'h808, 1'b1, 128'd0, 16'hFFFE);
        issue(3'b001, 27'h08, 1'b0, '0, '0);
        repeat (RD_LAT - 1) tick();
        check("alias_data", app_rd_data, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00);
        repeat (3) tick();

        // Fill indices 0..9, then read them back-to-back across a refresh stall
        for (int i = 0; i < 10; i++)
            issue(3'b000, 27'(i << 3), 1'b1, {4{32'hA5000000 | i}}, 16'h0000);
        wait_ref(PERIOD - RLEN - 3);
        stall_dut = 0;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        for (int i = 0; i < 10; i++) begin
            app_en = 1'b1; app_cmd = 3'b001; app_addr = 27'(i << 3);
            guard = 0;
            while (!exp_rdy() && guard < 20) begin
                if (app_rdy !== 1'b1) stall_dut++;
                tick();
                guard++;
            end
            if (guard >= 20) timeout_fail("burst_wait");
            if (app_rdy !== 1'b1) stall_dut++;
            tick();
        end
        app_en = 1'b0;
        check("stall_cycles", 128'(stall_dut), 128'd4);
        repeat (RD_LAT + 2) tick();
        check("burst_drained", 128'(rq.size()), 128'd0);

        // Bad command during the stall: no effect, no error
        wait_ref(PERIOD - RLEN);
        app_en = 1'b1; app_cmd = 3'b010; app_addr = 27'h40;
        repeat (RLEN) tick();
        app_en = 1'b0;
        check("stall_bad_perr", {127'd0, proto_err}, 128'd0);

        // Bad command while ready: sticky error, no response, memory intact
        issue(3'b010, 27'h40, 1'b0, '0, '0);
        check("perr_set", {127'd0, proto_err}, 128'd1);
        repeat (RD_LAT + 2) tick();
        check("perr_sticky", {127'd0, proto_err}, 128'd1);
        issue(3'b001, 27'h40, 1'b0, '0, '0);
        repeat (RD_LAT - 1) tick();
        check("perr_mem_intact", app_rd_data, {4{32'hA5000008}});
        tick();

        // Reset with three reads in flight
        wait_ref(10);
        issue(3'b001, 27'h40, 1'b0, '0, '0);
        issue(3'b001, 27'h48, 1'b0, '0, '0);
        issue(3'b001, 27'h50, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_perr_clr", {127'd0, proto_err}, 128'd0);
        rst_n = 1'b1;
        repeat (CALIB + RD_LAT) tick();
        check("recal_done", {127'd0, init_calib_complete}, 128'd1);
        issue(3'b001, 27'h40, 1'b0, '0, '0);
        repeat (RD_LAT - 1) tick();
        check("post_rst_data8", app_rd_data, {4{32'hA5000008}});
        issue(3'b001, 27'h08, 1'b0, '0, '0);
        repeat (RD_LAT - 1) tick();
        check("post_rst_data1", app_rd_data, {4{32'hA5000001}});
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
